// File: rtl/not_pipe_elastic.sv
// not_pipe_elastic: elastic valid/ready register pipeline with per-stage optional inversion
module not_pipe_elastic #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter logic [DEPTH-1:0] INV_MASK = DEPTH'(2'b10)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_cnt;
    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_up_v;
    logic [WIDTH-1:0] w_up_d [DEPTH];
    logic             w_in_hs;
    logic             w_out_hs;
    // Ready ripples back from the sink; an empty stage is always ready so bubbles collapse
    always_comb begin
        w_rdy = '0;
        w_rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) w_rdy[k] = !r_v[k] || w_rdy[k+1];
    end
    // Each stage's upstream source: the input port for stage 0, the previous stage otherwise
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_up_v[k] = (k == 0) ? in_valid : r_v[(k == 0) ? 0 : k-1];
            w_up_d[k] = (k == 0) ? in_data : r_d[(k == 0) ? 0 : k-1];
        end
    end
    assign in_ready  = w_rdy[0] && !flush;
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign count     = r_cnt;
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = r_v[DEPTH-1] && out_ready;
    // Stage registers and occupancy; flush clears valids but leaves data untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (flush) r_v[k] <= 1'b0;
                else if (w_rdy[k]) begin
                    r_v[k] <= w_up_v[k];
                    if (w_up_v[k]) r_d[k] <= w_up_d[k] ^ {WIDTH{INV_MASK[k]}};
                end
            end
            r_cnt <= flush ? '0 : r_cnt + CW'(w_in_hs) - CW'(w_out_hs);
        end
    end
endmodule

// File: tb/tb_not_pipe_elastic.sv
// tb_not_pipe_elastic: directed tests over four pipeline configurations
module tb_not_pipe_elastic;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int errs = 0;
    int checks = 0;
    // a: DEPTH=2 default mask; b: DEPTH=4 default mask; c: DEPTH=3 mask 111; e: DEPTH=3 mask 000
    logic a_iv = 0, a_ir, a_ov, a_or = 0;
    logic [7:0] a_id = 0, a_od;
    logic [1:0] a_cnt;
    logic b_iv = 0, b_ir, b_ov, b_or = 0;
    logic [7:0] b_id = 0, b_od;
    logic [2:0] b_cnt;
    logic c_iv = 0, c_ir, c_ov, c_or = 0;
    logic [7:0] c_id = 0, c_od;
    logic [1:0] c_cnt;
    logic e_iv = 0, e_ir, e_ov, e_or = 0;
    logic [7:0] e_id = 0, e_od;
    logic [1:0] e_cnt;

    always #5 clk = ~clk;

    not_pipe_elastic #(.WIDTH(8), .DEPTH(2)) u_a (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .out_valid(a_ov), .out_ready(a_or),
        .out_data(a_od), .count(a_cnt));
    not_pipe_elastic #(.WIDTH(8), .DEPTH(4)) u_b (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .out_valid(b_ov), .out_ready(b_or),
        .out_data(b_od), .count(b_cnt));
    not_pipe_elastic #(.WIDTH(8), .DEPTH(3), .INV_MASK(3'b111)) u_c (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .out_valid(c_ov), .out_ready(c_or),
        .out_data(c_od), .count(c_cnt));
    not_pipe_elastic #(.WIDTH(8), .DEPTH(3), .INV_MASK(3'b000)) u_e (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id), .out_valid(e_ov), .out_ready(e_or),
        .out_data(e_od), .count(e_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (a_ov !== 1'b0) begin errs++; $display("FAIL rst_ov got %0h exp 0", a_ov); end
        checks++; if (a_od !== 8'h00) begin errs++; $display("FAIL rst_od got %0h exp 00", a_od); end
        checks++; if (a_cnt !== 2'd0) begin errs++; $display("FAIL rst_cnt got %0d exp 0", a_cnt); end
        checks++; if (a_ir !== 1'b1) begin errs++; $display("FAIL rst_ir got %0h exp 1", a_ir); end
        tick();
        rst = 1'b0; a_or = 1'b1; a_iv = 1'b1; a_id = 8'h12;
        tick();
        a_id = 8'h34;
        tick();
        checks++; if (a_ov !== 1'b1 || a_od !== 8'hED) begin errs++; $display("FAIL pre_rst_out got %0h/%0h exp 1/ed", a_ov, a_od); end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_ov !== 1'b0) begin errs++; $display("FAIL midrst_ov got %0h exp 0", a_ov); end
        checks++; if (a_od !== 8'h00) begin errs++; $display("FAIL midrst_od got %0h exp 00", a_od); end
        checks++; if (a_cnt !== 2'd0) begin errs++; $display("FAIL midrst_cnt got %0d exp 0", a_cnt); end
        tick();
        rst = 1'b0; a_id = 8'h5A;
        tick();
        checks++; if (a_ov !== 1'b0 || a_cnt !== 2'd1) begin errs++; $display("FAIL postrst_1 got %0h/%0d exp 0/1", a_ov, a_cnt); end
        a_iv = 1'b0;
        tick();
        checks++; if (a_ov !== 1'b1 || a_od !== 8'hA5) begin errs++; $display("FAIL postrst_2 got %0h/%0h exp 1/a5", a_ov, a_od); end
        tick(); tick();
    endtask

    task automatic test_stream();
        a_or = 1'b1; a_iv = 1'b1; a_id = 8'h00;
        tick();
        checks++; if (a_ov !== 1'b0 || a_cnt !== 2'd1) begin errs++; $display("FAIL str_0 got %0h/%0d exp 0/1", a_ov, a_cnt); end
        a_id = 8'h5A;
        tick();
        checks++; if (a_ov !== 1'b1 || a_od !== 8'hFF || a_cnt !== 2'd2) begin errs++; $display("FAIL str_1 got %0h/%0h/%0d exp 1/ff/2", a_ov, a_od, a_cnt); end
        checks++; if (a_ir !== 1'b1) begin errs++; $display("FAIL str_ir_full got %0h exp 1", a_ir); end
        a_id = 8'hFF;
        tick();
        checks++; if (a_ov !== 1'b1 || a_od !== 8'hA5 || a_cnt !== 2'd2) begin errs++; $display("FAIL str_2 got %0h/%0h/%0d exp 1/a5/2", a_ov, a_od, a_cnt); end
        a_iv = 1'b0;
        tick();
        checks++; if (a_ov !== 1'b1 || a_od !== 8'h00 || a_cnt !== 2'd1) begin errs++; $display("FAIL str_3 got %0h/%0h/%0d exp 1/00/1", a_ov, a_od, a_cnt); end
        tick();
        checks++; if (a_ov !== 1'b0 || a_cnt !== 2'd0) begin errs++; $display("FAIL str_4 got %0h/%0d exp 0/0", a_ov, a_cnt); end
    endtask

    task automatic test_backpressure();
        a_or = 1'b0; a_iv = 1'b1; a_id = 8'h11;
        #1;
        checks++; if (a_ir !== 1'b1) begin errs++; $display("FAIL bp_ir0 got %0h exp 1", a_ir); end
        tick();
        a_id = 8'h22;
        checks++; if (a_ir !== 1'b1) begin errs++; $display("FAIL bp_ir1 got %0h exp 1", a_ir); end
        tick();
        a_id = 8'h33;
        checks++; if (a_ov !== 1'b1 || a_od !== 8'hEE || a_cnt !== 2'd2 || a_ir !== 1'b0) begin errs++; $display("FAIL bp_full got %0h/%0h/%0d/%0h exp 1/ee/2/0", a_ov, a_od, a_cnt, a_ir); end
        tick();
        checks++; if (a_od !== 8'hEE || a_cnt !== 2'd2 || a_ir !== 1'b0) begin errs++; $display("FAIL bp_hold got %0h/%0d/%0h exp ee/2/0", a_od, a_cnt, a_ir); end
        a_or = 1'b1;
        #1;
        checks++; if (a_ir !== 1'b1) begin errs++; $display("FAIL bp_ir_release got %0h exp 1", a_ir); end
        tick();
        a_iv = 1'b0;
        checks++; if (a_ov !== 1'b1 || a_od !== 8'hDD || a_cnt !== 2'd2) begin errs++; $display("FAIL bp_dd got %0h/%0h/%0d exp 1/dd/2", a_ov, a_od, a_cnt); end
        tick();
        checks++; if (a_ov !== 1'b1 || a_od !== 8'hCC || a_cnt !== 2'd1) begin errs++; $display("FAIL bp_cc got %0h/%0h/%0d exp 1/cc/1", a_ov, a_od, a_cnt); end
        tick();
        checks++; if (a_ov !== 1'b0 || a_cnt !== 2'd0) begin errs++; $display("FAIL bp_empty got %0h/%0d exp 0/0", a_ov, a_cnt); end
    endtask

    task automatic test_bubble();
        logic [7:0] exp_d;
        b_or = 1'b0; b_iv = 1'b1; b_id = 8'h01;
        tick();
        b_iv = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (b_ov !== 1'b1 || b_od !== 8'hFE || b_cnt !== 3'd1) begin errs++; $display("FAIL bub_first got %0h/%0h/%0d exp 1/fe/1", b_ov, b_od, b_cnt); end
        for (int i = 0; i < 3; i++) begin
            b_iv = 1'b1; b_id = 8'(i + 2);
            #1;
            checks++; if (b_ir !== 1'b1) begin errs++; $display("FAIL bub_acc%0d got %0h exp 1", i, b_ir); end
            tick();
        end
        checks++; if (b_cnt !== 3'd4 || b_ir !== 1'b0) begin errs++; $display("FAIL bub_full got %0d/%0h exp 4/0", b_cnt, b_ir); end
        b_iv = 1'b0; b_or = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(i + 1);
            exp_d = ~exp_d;
            #1;
            checks++; if (b_ov !== 1'b1 || b_od !== exp_d) begin errs++; $display("FAIL bub_drain%0d got %0h/%0h exp 1/%0h", i, b_ov, b_od, exp_d); end
            tick();
        end
        checks++; if (b_ov !== 1'b0 || b_cnt !== 3'd0) begin errs++; $display("FAIL bub_empty got %0h/%0d exp 0/0", b_ov, b_cnt); end
    endtask

    task automatic test_flush();
        c_or = 1'b0; c_iv = 1'b1; c_id = 8'hAA;
        tick();
        c_id = 8'hBB;
        tick();
        checks++; if (c_cnt !== 2'd2) begin errs++; $display("FAIL fl_pre got %0d exp 2", c_cnt); end
        flush = 1'b1; c_id = 8'hCC;
        #1;
        checks++; if (c_ir !== 1'b0) begin errs++; $display("FAIL fl_ir got %0h exp 0", c_ir); end
        tick();
        flush = 1'b0; c_iv = 1'b0;
        checks++; if (c_cnt !== 2'd0 || c_ov !== 1'b0) begin errs++; $display("FAIL fl_post got %0d/%0h exp 0/0", c_cnt, c_ov); end
        tick();
        checks++; if (c_cnt !== 2'd0 || c_ov !== 1'b0) begin errs++; $display("FAIL fl_stay got %0d/%0h exp 0/0", c_cnt, c_ov); end
    endtask

    task automatic test_mask();
        c_or = 1'b1; e_or = 1'b1;
        c_iv = 1'b1; c_id = 8'h3C; e_iv = 1'b1; e_id = 8'h3C;
        tick();
        c_iv = 1'b0; e_iv = 1'b0;
        tick();
        checks++; if (c_ov !== 1'b0 || e_ov !== 1'b0) begin errs++; $display("FAIL mask_early got %0h/%0h exp 0/0", c_ov, e_ov); end
        tick();
        checks++; if (c_ov !== 1'b1 || c_od !== 8'hC3) begin errs++; $display("FAIL mask111 got %0h/%0h exp 1/c3", c_ov, c_od); end
        checks++; if (e_ov !== 1'b1 || e_od !== 8'h3C) begin errs++; $display("FAIL mask000 got %0h/%0h exp 1/3c", e_ov, e_od); end
        tick();
        checks++; if (c_ov !== 1'b0 || e_ov !== 1'b0) begin errs++; $display("FAIL mask_drain got %0h/%0h exp 0/0", c_ov, e_ov); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_mask();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
